// File: rtl/vga_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter_if
// Signal bundle between the frame-buffer arbiter and its environment: the
// timing block (blank), the display scan-out fetch, the draw engine and the
// single-port frame RAM.
//
// Modports
//   slave  : arbiter side. Takes blank, both requests and RAM read data.
//            Drives the grants, read returns, the RAM command and underrun.
//   master : environment side, the mirror image of slave.
//
// Parameters
//   ADDR_W : frame-buffer word address width
//   DATA_W : frame-buffer word width
// ---------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) ();
    logic              blank;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              draw_req;
    logic              draw_we;
    logic [ADDR_W-1:0] draw_addr;
    logic [DATA_W-1:0] draw_wdata;
    logic              draw_gnt;
    logic              draw_rvalid;
    logic [DATA_W-1:0] draw_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              underrun;

    modport slave (
        input  blank,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  draw_req, draw_we, draw_addr, draw_wdata,
        output draw_gnt, draw_rvalid, draw_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output underrun
    );

    modport master (
        output blank,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output draw_req, draw_we, draw_addr, draw_wdata,
        input  draw_gnt, draw_rvalid, draw_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  underrun
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port frame RAM between the display scan-out fetch and the
// draw engine, all in the clk50 domain.
//   - Active video (blank=0): the display wins whenever it requests.
//   - Blanking (blank=1): a lone request wins; with both pending, a
//     round-robin pointer alternates the winner.
//   - Grants are combinational. The RAM command is registered one cycle after
//     the grant, and read data returns to the owner two cycles after it.
//   - underrun is a sticky flag raised when a display request has waited
//     UNDERRUN_LIM consecutive cycles.
//
// Optional build macro
//   VGA_FB_STARVE_EN : in active video, a draw request that has waited
//                      STARVE_MAX consecutive cycles takes one grant from
//                      the display.
//
// Ports
//   clk50 : 50 MHz system clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_fb_arbiter_if.slave (requesters, RAM command/data, underrun)
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int STARVE_MAX   = 8,
    parameter int UNDERRUN_LIM = 2
) (
    input  logic            clk50,
    input  logic            rst_n,
    vga_fb_arbiter_if.slave bus
);
    typedef enum logic {SRC_DISP = 1'b0, SRC_DRAW = 1'b1} src_e;

    localparam int              DW_W   = $clog2(UNDERRUN_LIM + 1);
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(UNDERRUN_LIM);
    localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);

    src_e              rr_q;          // requester preferred on a blanking tie
    logic              disp_gnt, draw_gnt;
    logic              force_draw;

    // Command stage: what the RAM sees, plus the owner of that access.
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    src_e              src1_q;

    // Return stage: a read issued last cycle has its data on mem_rdata now.
    logic              rd2_q;
    src_e              src2_q;
    logic              disp_rvalid, draw_rvalid;
    logic [DATA_W-1:0] disp_hold_q, draw_hold_q;

    logic [DW_W-1:0]   disp_wait_q, disp_wait_d;
    logic              underrun_q;

`ifdef VGA_FB_STARVE_EN
    localparam int              SW_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SW_W-1:0] SW_MAX = SW_W'(STARVE_MAX);
    localparam logic [SW_W-1:0] SW_ONE = SW_W'(1);

    logic [SW_W-1:0] draw_wait_q, draw_wait_d;

    assign force_draw = !bus.blank && bus.draw_req && (draw_wait_q == SW_MAX);

    always_comb begin
        draw_wait_d = '0;
        if (bus.draw_req && !draw_gnt)
            draw_wait_d = (draw_wait_q == SW_MAX) ? SW_MAX : draw_wait_q + SW_ONE;
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) draw_wait_q <= '0;
        else        draw_wait_q <= draw_wait_d;
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_MAX == 0);
    assign force_draw        = 1'b0;
`endif

    // Arbitration looks only at the current blank, so a phase change takes
    // effect in the same cycle and never withholds a grant.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        disp_gnt = 1'b0;
        draw_gnt = 1'b0;
        if (!bus.blank) begin
            if (force_draw)        draw_gnt = 1'b1;
            else if (bus.disp_req) disp_gnt = 1'b1;
            else                   draw_gnt = bus.draw_req;
        end else if (bus.disp_req && bus.draw_req) begin
            disp_gnt = (rr_q == SRC_DISP);
            draw_gnt = (rr_q == SRC_DRAW);
        end else begin
            disp_gnt = bus.disp_req;
            draw_gnt = bus.draw_req;
        end
    end

    always_comb begin
        disp_wait_d = '0;
        if (bus.disp_req && !disp_gnt)
            disp_wait_d = (disp_wait_q == DW_MAX) ? DW_MAX : disp_wait_q + DW_ONE;
    end

    assign disp_rvalid = rd2_q && (src2_q == SRC_DISP);
    assign draw_rvalid = rd2_q && (src2_q == SRC_DRAW);

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= SRC_DISP;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            src1_q      <= SRC_DISP;
            rd2_q       <= 1'b0;
            src2_q      <= SRC_DISP;
            disp_hold_q <= '0;
            draw_hold_q <= '0;
            disp_wait_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            mem_en_q <= disp_gnt | draw_gnt;
            mem_we_q <= draw_gnt & bus.draw_we;
            // Address and write data hold their last value when nothing is granted.
            if (disp_gnt) begin
                mem_addr_q <= bus.disp_addr;
                src1_q     <= SRC_DISP;
            end else if (draw_gnt) begin
                mem_addr_q  <= bus.draw_addr;
                mem_wdata_q <= bus.draw_wdata;
                src1_q      <= SRC_DRAW;
            end

            rd2_q  <= mem_en_q & ~mem_we_q;
            src2_q <= src1_q;

            if (disp_rvalid) disp_hold_q <= bus.mem_rdata;
            if (draw_rvalid) draw_hold_q <= bus.mem_rdata;

            // The pointer always moves away from whoever just won.
            if (disp_gnt)      rr_q <= SRC_DRAW;
            else if (draw_gnt) rr_q <= SRC_DISP;

            disp_wait_q <= disp_wait_d;
            if (disp_wait_d == DW_MAX) underrun_q <= 1'b1;
        end
    end

    assign bus.disp_gnt    = disp_gnt;
    assign bus.draw_gnt    = draw_gnt;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.disp_rvalid = disp_rvalid;
    assign bus.draw_rvalid = draw_rvalid;
    // Read data goes straight through in the return cycle and is held otherwise.
    assign bus.disp_rdata  = disp_rvalid ? bus.mem_rdata : disp_hold_q;
    assign bus.draw_rdata  = draw_rvalid ? bus.mem_rdata : draw_hold_q;
    assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Self-checking bench for vga_fb_arbiter. It contains a frame-RAM model, a
// table of arbitration vectors, hand-written multi-cycle sequences, and a
// randomized run checked against a transaction-level reference model.
// Expectations follow VGA_FB_STARVE_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;
    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 8;
    localparam int STARVE_MAX   = 8;
    localparam int UNDERRUN_LIM = 2;
`ifdef VGA_FB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX), .UNDERRUN_LIM(UNDERRUN_LIM)
    ) dut (
        .clk50(clk50),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk50 = ~clk50;

    // Frame RAM model: one access per cycle, read data one cycle after mem_en.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk50) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic idle_inputs();
        bus.blank      = 1'b0;
        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.draw_req   = 1'b0;
        bus.draw_we    = 1'b0;
        bus.draw_addr  = '0;
        bus.draw_wdata = '0;
    endtask

    // Ends at posedge+1 with rst_n released and all inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk50);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic blank, disp_req, draw_req;
        logic exp_d, exp_w;
    } vec_t;

    typedef struct {
        int                due;
        bit                is_draw;
        logic [DATA_W-1:0] data;
    } rd_t;

    vec_t vecs [14];

    // Reference-model state for the randomized run.
    logic [DATA_W-1:0] mram [0:15];
    rd_t               rq [$];
    rd_t               r;
    int                m_dwait, m_wwait, nd, nw, first_draw;
    bit                m_underrun, last_draw_won, xd, xw, xdv, xwv;
    logic              e_en, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, last_d, last_w;

    initial begin
        idle_inputs();
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= DATA_W'($urandom);
        ram[16'h0010] <= 8'hA5;

        // --- Reset release, no requests -----------------------------------
        do_reset();
        #1;
        check("rst disp_gnt",    bus.disp_gnt, 0);
        check("rst draw_gnt",    bus.draw_gnt, 0);
        check("rst mem_en",      bus.mem_en, 0);
        check("rst mem_we",      bus.mem_we, 0);
        check("rst mem_addr",    bus.mem_addr, 0);
        check("rst mem_wdata",   bus.mem_wdata, 0);
        check("rst disp_rvalid", bus.disp_rvalid, 0);
        check("rst draw_rvalid", bus.draw_rvalid, 0);
        check("rst disp_rdata",  bus.disp_rdata, 0);
        check("rst draw_rdata",  bus.draw_rdata, 0);
        check("rst underrun",    bus.underrun, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            #1 check($sformatf("idle%0d mem_en", i), bus.mem_en, 0);
        end

        // --- ACTIVE display read, 2-cycle latency --------------------------
        do_reset();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 15'h0010;
        #1 check("rd N disp_gnt", bus.disp_gnt, 1);
        tick();
        bus.disp_req = 1'b0;
        #1;
        check("rd N+1 mem_en",      bus.mem_en, 1);
        check("rd N+1 mem_we",      bus.mem_we, 0);
        check("rd N+1 mem_addr",    bus.mem_addr, 15'h0010);
        check("rd N+1 disp_rvalid", bus.disp_rvalid, 0);
        tick();
        #1;
        check("rd N+2 disp_rvalid", bus.disp_rvalid, 1);
        check("rd N+2 disp_rdata",  bus.disp_rdata, 8'hA5);
        check("rd N+2 draw_rvalid", bus.draw_rvalid, 0);
        check("rd N+2 mem_en",      bus.mem_en, 0);
        tick();
        #1;
        check("rd N+3 disp_rvalid", bus.disp_rvalid, 0);
        check("rd N+3 disp_rdata",  bus.disp_rdata, 8'hA5);

        // --- ACTIVE, both requests held for 20 cycles -----------------------
        do_reset();
        bus.disp_req  = 1'b1;
        bus.draw_req  = 1'b1;
        bus.disp_addr = 15'd3;
        bus.draw_addr = 15'd4;
        nd = 0; nw = 0; first_draw = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("act%0d one gnt", i), {31'd0, bus.disp_gnt & bus.draw_gnt}, 0);
            if (bus.disp_gnt) nd++;
            if (bus.draw_gnt) begin
                nw++;
                if (first_draw < 0) first_draw = i;
            end
            tick();
        end
        idle_inputs();
        #1;
        check("act disp grants", nd, STARVE_ON ? 18 : 20);
        check("act draw grants", nw, STARVE_ON ? 2 : 0);
        check("act first draw",  first_draw, STARVE_ON ? 8 : -1);
        check("act underrun",    bus.underrun, 0);

        // --- BLANK, both requests from reset alternate ----------------------
        do_reset();
        bus.blank    = 1'b1;
        bus.disp_req = 1'b1;
        bus.draw_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d disp_gnt", i), bus.disp_gnt, (i % 2) == 0);
            check($sformatf("rr%0d draw_gnt", i), bus.draw_gnt, (i % 2) == 1);
            tick();
        end

        // --- BLANK draw write ----------------------------------------------
        do_reset();
        bus.blank      = 1'b1;
        bus.draw_req   = 1'b1;
        bus.draw_we    = 1'b1;
        bus.draw_addr  = 15'h1234;
        bus.draw_wdata = 8'h3C;
        #1 check("wr N draw_gnt", bus.draw_gnt, 1);
        tick();
        bus.draw_req = 1'b0;
        #1;
        check("wr N+1 mem_en",    bus.mem_en, 1);
        check("wr N+1 mem_we",    bus.mem_we, 1);
        check("wr N+1 mem_addr",  bus.mem_addr, 15'h1234);
        check("wr N+1 mem_wdata", bus.mem_wdata, 8'h3C);
        tick();
        #1;
        check("wr N+2 draw_rvalid", bus.draw_rvalid, 0);
        check("wr N+2 mem_we",      bus.mem_we, 0);
        tick();
        #1 check("wr N+3 draw_rvalid", bus.draw_rvalid, 0);

        // --- Reset asserted with a read in flight ---------------------------
        do_reset();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 15'h0010;
        #1 check("mid N disp_gnt", bus.disp_gnt, 1);
        tick();
        bus.disp_req = 1'b0;
        #1 check("mid N+1 mem_en", bus.mem_en, 1);
        rst_n = 1'b0;
        #1 check("mid async mem_en", bus.mem_en, 0);
        repeat (2) @(posedge clk50);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("mid post%0d disp_rvalid", i), bus.disp_rvalid, 0);
            tick();
        end
        check("mid underrun", bus.underrun, 0);
        bus.blank    = 1'b1;
        bus.disp_req = 1'b1;
        bus.draw_req = 1'b1;
        #1;
        check("mid rr disp_gnt", bus.disp_gnt, 1);
        check("mid rr draw_gnt", bus.draw_gnt, 0);

        // --- Table-driven arbitration sequence from reset -------------------
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus.blank     = vecs[i].blank;
            bus.disp_req  = vecs[i].disp_req;
            bus.draw_req  = vecs[i].draw_req;
            bus.disp_addr = ADDR_W'(i);
            bus.draw_addr = ADDR_W'(i + 100);
            #1;
            check($sformatf("vec%0d disp_gnt", i), bus.disp_gnt, vecs[i].exp_d);
            check($sformatf("vec%0d draw_gnt", i), bus.draw_gnt, vecs[i].exp_w);
            tick();
        end

        // --- Randomized run against a transaction-level model ---------------
        do_reset();
        for (int i = 0; i < 16; i++) mram[i] = ram[i];
        rq.delete();
        m_dwait = 0; m_wwait = 0; m_underrun = 1'b0;
        last_draw_won = 1'b1;              // display preferred after reset
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        last_d = '0; last_w = '0;
        for (int c = 0; c < 2500; c++) begin
            #1;
            check($sformatf("R%0d mem_en", c),   bus.mem_en, e_en);
            check($sformatf("R%0d mem_we", c),   bus.mem_we, e_we);
            check($sformatf("R%0d mem_addr", c), bus.mem_addr, e_addr);
            if (e_we) check($sformatf("R%0d mem_wdata", c), bus.mem_wdata, e_wdata);

            xdv = 1'b0; xwv = 1'b0;
            if (rq.size() != 0 && rq[0].due == c) begin
                r = rq.pop_front();
                if (r.is_draw) begin xwv = 1'b1; last_w = r.data; end
                else           begin xdv = 1'b1; last_d = r.data; end
            end
            check($sformatf("R%0d disp_rvalid", c), bus.disp_rvalid, xdv);
            check($sformatf("R%0d draw_rvalid", c), bus.draw_rvalid, xwv);
            check($sformatf("R%0d disp_rdata", c),  bus.disp_rdata, last_d);
            check($sformatf("R%0d draw_rdata", c),  bus.draw_rdata, last_w);
            check($sformatf("R%0d underrun", c),    bus.underrun, m_underrun);

            xd = 1'b0; xw = 1'b0;
            if (!bus.blank) begin
                if (STARVE_ON && bus.draw_req && m_wwait >= STARVE_MAX) xw = 1'b1;
                else if (bus.disp_req) xd = 1'b1;
                else                   xw = bus.draw_req;
            end else if (bus.disp_req && bus.draw_req) begin
                if (last_draw_won) xd = 1'b1;
                else               xw = 1'b1;
            end else begin
                xd = bus.disp_req;
                xw = bus.draw_req;
            end
            check($sformatf("R%0d disp_gnt", c), bus.disp_gnt, xd);
            check($sformatf("R%0d draw_gnt", c), bus.draw_gnt, xw);

            e_en = xd | xw;
            e_we = xw & bus.draw_we;
            if (xd) begin
                e_addr = bus.disp_addr;
                r = '{c + 2, 1'b0, mram[bus.disp_addr[3:0]]};
                rq.push_back(r);
                last_draw_won = 1'b0;
            end
            if (xw) begin
                e_addr = bus.draw_addr;
                last_draw_won = 1'b1;
                if (bus.draw_we) begin
                    e_wdata = bus.draw_wdata;
                    mram[bus.draw_addr[3:0]] = bus.draw_wdata;
                end else begin
                    r = '{c + 2, 1'b1, mram[bus.draw_addr[3:0]]};
                    rq.push_back(r);
                end
            end
            m_dwait = (bus.disp_req && !xd) ? ((m_dwait < UNDERRUN_LIM) ? m_dwait + 1 : m_dwait) : 0;
            m_wwait = (bus.draw_req && !xw) ? ((m_wwait < STARVE_MAX) ? m_wwait + 1 : m_wwait) : 0;
            if (m_dwait >= UNDERRUN_LIM) m_underrun = 1'b1;

            tick();
            if (!bus.disp_req || xd) begin
                bus.disp_req  = ($urandom_range(0, 99) < 55);
                bus.disp_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!bus.draw_req || xw) begin
                bus.draw_req   = ($urandom_range(0, 99) < 60);
                bus.draw_we    = $urandom_range(0, 1) == 1;
                bus.draw_addr  = ADDR_W'($urandom_range(0, 15));
                bus.draw_wdata = DATA_W'($urandom);
            end
            if ($urandom_range(0, 9) == 0) bus.blank = ~bus.blank;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
